// File: rtl/asg_stream.sv
// Alternating step generator: three Fibonacci LFSRs, keystream bits packed MSB-first
// into OUT_W-bit words behind a valid/ready hold. Optional ASG_LOCKUP_GUARD_EN macro.
module asg_stream #(
    parameter int              WIDTH     = 16,
    parameter int              OUT_W     = 8,
    parameter logic [WIDTH-1:0] TAPS_CTRL = WIDTH'(16'h002D),
    parameter logic [WIDTH-1:0] TAPS_0    = WIDTH'(16'h0039),
    parameter logic [WIDTH-1:0] TAPS_1    = WIDTH'(16'h0071)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_ctrl,
    input  logic [WIDTH-1:0] seed_0,
    input  logic [WIDTH-1:0] seed_1,
    input  logic             en,
    output logic [WIDTH-1:0] out_state,
    output logic [OUT_W-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lockup
);

    localparam int             CNT_W    = $clog2(OUT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ctrl_q, ctrl_d;
    logic [WIDTH-1:0] lfsr0_q, lfsr0_d;
    logic [WIDTH-1:0] lfsr1_q, lfsr1_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [OUT_W-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] nxt0, nxt1;
    logic [WIDTH-1:0] ld_ctrl, ld_0, ld_1;
    logic             fc;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v,
                                                   input logic [WIDTH-1:0] taps);
        return {^(v & taps), v[WIDTH-1:1]};
    endfunction

`ifdef ASG_LOCKUP_GUARD_EN
    logic lock_q, lock_d;

    // A zero seed would freeze its LFSR forever; substitute 1 instead.
    function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] v);
        return (v == '0) ? WIDTH'(1) : v;
    endfunction

    assign ld_ctrl = seed_fix(seed_ctrl);
    assign ld_0    = seed_fix(seed_0);
    assign ld_1    = seed_fix(seed_1);
    assign lock_d  = load && ((seed_ctrl == '0) || (seed_0 == '0) || (seed_1 == '0));
    assign lockup  = lock_q;
`else
    assign ld_ctrl = seed_ctrl;
    assign ld_0    = seed_0;
    assign ld_1    = seed_1;
    assign lockup  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        lfsr0_d = lfsr0_q;
        lfsr1_d = lfsr1_q;
        st_d    = st_q;
        word_d  = word_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        fc      = ^(ctrl_q & TAPS_CTRL);
        nxt0    = lfsr0_q;
        nxt1    = lfsr1_q;
        if (fc) nxt1 = lfsr_step(lfsr1_q, TAPS_1);
        else    nxt0 = lfsr_step(lfsr0_q, TAPS_0);

        if (load) begin
            ctrl_d  = ld_ctrl;
            lfsr0_d = ld_0;
            lfsr1_d = ld_1;
            st_d    = ld_0 ^ ld_1;
            word_d  = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        ctrl_d  = {fc, ctrl_q[WIDTH-1:1]};
                        lfsr0_d = nxt0;
                        lfsr1_d = nxt1;
                        st_d    = nxt0 ^ nxt1;
                        word_d  = {word_q[OUT_W-2:0], nxt0[0] ^ nxt1[0]};
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                // Accepting cycle only hands the word over; stepping resumes next cycle.
                HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_d = 1'b0;
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            lfsr0_q <= '0;
            lfsr1_q <= '0;
            st_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            lfsr0_q <= lfsr0_d;
            lfsr1_q <= lfsr1_d;
            st_q    <= st_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ASG_LOCKUP_GUARD_EN
    always_ff @(posedge clock) begin
        if (!reset) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`endif

    assign out_state = st_q;
    assign out_word  = word_q;
    assign out_valid = valid_q;

endmodule

// File: doc/asg_stream.md
# asg_stream

Parametrised alternating step generator with a word-packing output stage and a valid/ready handshake. Three Fibonacci LFSRs of configurable width and tap masks work together. The control LFSR's feedback bit selects which data LFSR steps on each enabled cycle. The keystream bit is the XOR of both data LFSR LSBs, and bits are packed into OUT_W-bit words. It sits between the seed/config logic and any keystream consumer, replacing the fixed 4-bit generator for all new designs.

## Interface
- WIDTH, 16: width of all three LFSRs; minimum 4.
- OUT_W, 8: bits per output word; range 2..32.
- TAPS_CTRL, 16'h002D: control LFSR feedback tap mask (WIDTH bits).
- TAPS_0, 16'h0039: data LFSR 0 tap mask.
- TAPS_1, 16'h0071: data LFSR 1 tap mask.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- load  in  1  single-cycle seed load strobe.
- seed_ctrl  in  WIDTH  control LFSR seed; sampled when load=1.
- seed_0  in  WIDTH  data LFSR 0 seed; sampled when load=1.
- seed_1  in  WIDTH  data LFSR 1 seed; sampled when load=1.
- en  in  1  step enable; honoured only in RUN.
- out_state  out  WIDTH  registered LFSR_0 ^ LFSR_1.
- out_word  out  OUT_W  packed keystream word.
- out_valid  out  1  out_word is complete and held.
- out_ready  in  1  consumer accepts out_word.
- lockup  out  1  one-cycle pulse when a zero seed was substituted.

## Operation
- The FSM has three states: IDLE, RUN and HOLD.
- Reset (reset=0 at the clock edge) sets the following, overriding everything else:
  - all LFSRs, out_state, out_word and the bit counter to 0
  - out_valid=0, lockup=0
  - state to IDLE
- IDLE: ignores en and out_ready. Goes to RUN on load.
- load, accepted in any state and with priority over stepping and handshake:
  - captures all three seeds
  - clears the bit counter and out_word
  - sets out_valid=0 and out_state=seed_0^seed_1
  - goes to RUN
- A step in RUN with en=1 and load=0:
  - fc = ^(ctrl & TAPS_CTRL); ctrl <= {fc, ctrl[WIDTH-1:1]}.
  - If fc=1, LFSR_1 shifts the same way using TAPS_1. Otherwise LFSR_0 shifts using TAPS_0. The other data LFSR holds.
  - bit = new LFSR_0[0] ^ new LFSR_1[0]; out_word <= {out_word[OUT_W-2:0], bit}, so the first bit ends up in the MSB.
  - out_state <= new LFSR_0 ^ new LFSR_1; the bit counter increments.
- When the step that completes the OUT_W-th bit occurs: set out_valid=1, go to HOLD and clear the counter.
- RUN with en=0: no register changes.
- HOLD:
  - All LFSRs, out_word and out_state are frozen, and en is ignored; this is backpressure.
  - When out_valid=1 and out_ready=1: out_valid drops next cycle and the state returns to RUN. No step occurs in the accepting cycle.
- out_ready while out_valid=0 has no effect.

## Timing
- All outputs are registered.
- From load to the first out_valid: exactly 1 + OUT_W clocks with en held high.
- Sustained throughput with out_ready tied high: one word per OUT_W+1 clocks.
- Reset mid-word or in HOLD discards the partial or held word. The next word requires a new load.
- load in HOLD drops the pending word without it being accepted.

## Configuration
- Macro: ASG_LOCKUP_GUARD_EN.
- Defined: at load, any all-zero seed is replaced with WIDTH'd1, and lockup pulses high for the cycle after the load.
- Undefined: seeds load verbatim, an all-zero LFSR stays zero permanently, and lockup is tied to 0.

## Test plan
- Settings: WIDTH=4, OUT_W=4, all taps 4'b0011.
  - Stimulus: load with seed_ctrl=4'b1000, seed_0=4'b0001, seed_1=4'b0010, then en=1 for 4 cycles.
  - Required: out_word=4'b0010 with out_valid=1 on the 5th clock after load, and out_state=4'b1000.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD with en=1 -> out_word, out_state and the LFSRs do not change. Then out_ready=1 for 1 cycle -> out_valid=0 next cycle.
- Reset: drive reset=0 mid-word after 2 steps -> next cycle all outputs are 0 and the state is IDLE. en pulses afterwards have no effect until load.
- Lockup, with the macro defined: load seed_0=0 -> lockup=1 for 1 cycle and LFSR_0 starts at 1. With the macro undefined: lockup=0 and all stepping of LFSR_0 produces 0.
- Defaults: WIDTH=16, OUT_W=8, random seeds, 1000 words with random en/out_ready -> bit-exact match against a reference model.
